// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file writeback controller.
package regfile_pkg;

    localparam int NUM_REGS = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xlen_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_t;

    // One-hot decode of a register address into a bitmap lane
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
        logic [NUM_REGS-1:0] oh;
        oh = {NUM_REGS{1'b0}};
        oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bitmap of in-flight destination registers with read-hazard stall and idle flags.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      iss_valid,
    input  reg_addr_t iss_rd,
    input  logic      rf_we,
    input  reg_addr_t rf_wa,
    input  reg_addr_t chk_ra1,
    input  reg_addr_t chk_ra2,
    output logic      stall,
    output logic      idle
);

    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;
    logic                haz1_s;
    logic                haz2_s;

    // A source is hazardous unless the write port delivers it this very cycle
    function automatic logic src_hazard(input reg_addr_t ra, input logic [NUM_REGS-1:0] busy,
                                        input logic we, input reg_addr_t wa);
        return (ra != 5'd0) && busy[ra] && !(we && (wa == ra));
    endfunction

    // Next busy bitmap: set wins over clear, lane 0 never set
    always_comb begin
        set_mask_s = (iss_valid && (iss_rd != 5'd0)) ? reg_onehot(iss_rd) : {NUM_REGS{1'b0}};
        clr_mask_s = rf_we ? reg_onehot(rf_wa) : {NUM_REGS{1'b0}};
        busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~{{(NUM_REGS-1){1'b0}}, 1'b1};
    end

    // Busy bitmap register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= {NUM_REGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    // Hazard and idle indications
    always_comb begin
        haz1_s = src_hazard(chk_ra1, busy_q, rf_we, rf_wa);
        haz2_s = src_hazard(chk_ra2, busy_q, rf_we, rf_wa);
        stall  = reset && (haz1_s || haz2_s);
        idle   = (busy_q == {NUM_REGS{1'b0}});
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback arbiter (ALU vs LSU) driving a registered register-file write port.
// Optional macro WB_ARB_RR_EN: round-robin arbitration; otherwise LSU has fixed priority.
module regfile_wb_ctrl
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      alu_valid,
    input  reg_addr_t alu_rd,
    input  xlen_t     alu_data,
    output logic      alu_ready,
    input  logic      lsu_valid,
    input  reg_addr_t lsu_rd,
    input  xlen_t     lsu_data,
    output logic      lsu_ready,
    output logic      rf_we,
    output reg_addr_t rf_wa,
    output xlen_t     rf_wd,
    input  logic      iss_valid,
    input  reg_addr_t iss_rd,
    input  reg_addr_t chk_ra1,
    input  reg_addr_t chk_ra2,
    output logic      stall,
    output logic      idle
);

    wb_src_t   sel_src_s;
    logic      lsu_wins_s;
    logic      xfer_s;
    reg_addr_t sel_rd_s;
    xlen_t     sel_data_s;
    logic      rf_we_d;
    logic      rf_we_q;
    reg_addr_t rf_wa_d;
    reg_addr_t rf_wa_q;
    xlen_t     rf_wd_d;
    xlen_t     rf_wd_q;

`ifdef WB_ARB_RR_EN
    wb_src_t last_d;
    wb_src_t last_q;
`endif

    // Arbitration, grants and next write-port values
    always_comb begin
`ifdef WB_ARB_RR_EN
        lsu_wins_s = (last_q == WB_ALU);
`else
        lsu_wins_s = 1'b1;
`endif
        if (lsu_valid && (!alu_valid || lsu_wins_s)) begin
            sel_src_s = WB_LSU;
        end else begin
            sel_src_s = WB_ALU;
        end
        alu_ready  = reset && alu_valid && (sel_src_s == WB_ALU);
        lsu_ready  = reset && lsu_valid && (sel_src_s == WB_LSU);
        xfer_s     = alu_ready || lsu_ready;
        sel_rd_s   = (sel_src_s == WB_LSU) ? lsu_rd : alu_rd;
        sel_data_s = (sel_src_s == WB_LSU) ? lsu_data : alu_data;
        // x0 writes are accepted but never reach the register file
        rf_we_d    = xfer_s && (sel_rd_s != 5'd0);
        if (xfer_s) begin
            rf_wa_d = sel_rd_s;
            rf_wd_d = sel_data_s;
        end else begin
            rf_wa_d = rf_wa_q;
            rf_wd_d = rf_wd_q;
        end
`ifdef WB_ARB_RR_EN
        if (xfer_s) begin
            last_d = sel_src_s;
        end else begin
            last_d = last_q;
        end
`endif
    end

    // Write-port output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_q <= 1'b0;
            rf_wa_q <= 5'd0;
            rf_wd_q <= 32'd0;
        end else begin
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
        end
    end

`ifdef WB_ARB_RR_EN
    // Last-grant register for round-robin fairness
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= WB_ALU;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign rf_we = rf_we_q;
    assign rf_wa = rf_wa_q;
    assign rf_wd = rf_wd_q;

    regfile_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rf_we     (rf_we_q),
        .rf_wa     (rf_wa_q),
        .chk_ra1   (chk_ra1),
        .chk_ra2   (chk_ra2),
        .stall     (stall),
        .idle      (idle)
    );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: vector table with write-port scoreboard, plus hazard/reset sequences.
module tb_regfile_wb_ctrl;
    import regfile_pkg::*;

    logic      clk;
    logic      reset;
    logic      alu_valid;
    reg_addr_t alu_rd;
    xlen_t     alu_data;
    logic      alu_ready;
    logic      lsu_valid;
    reg_addr_t lsu_rd;
    xlen_t     lsu_data;
    logic      lsu_ready;
    logic      rf_we;
    reg_addr_t rf_wa;
    xlen_t     rf_wd;
    logic      iss_valid;
    reg_addr_t iss_rd;
    reg_addr_t chk_ra1;
    reg_addr_t chk_ra2;
    logic      stall;
    logic      idle;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic      av;
        reg_addr_t ard;
        xlen_t     adata;
        logic      lv;
        reg_addr_t lrd;
        xlen_t     ldata;
        logic      exp_ar;
        logic      exp_lr;
    } vec_t;

    typedef struct {
        logic      we;
        reg_addr_t wa;
        xlen_t     wd;
    } wb_t;

    vec_t vecs[12];
    wb_t  exp_q[$];
    wb_t  model;
    wb_t  got;

    regfile_wb_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .lsu_valid (lsu_valid),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .lsu_ready (lsu_ready),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .chk_ra1   (chk_ra1),
        .chk_ra2   (chk_ra2),
        .stall     (stall),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
        iss_valid = 1'b0; iss_rd = 5'd0;
    endtask

    task automatic set_vec(input int i, input logic av, input reg_addr_t ard, input xlen_t ad,
                           input logic lv, input reg_addr_t lrd, input xlen_t ld,
                           input logic ear, input logic elr);
        vecs[i] = '{av, ard, ad, lv, lrd, ld, ear, elr};
    endtask

    initial begin
        drive_idle();
        chk_ra1 = 5'd0;
        chk_ra2 = 5'd0;
        reset   = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #12;
        // Reset state, including ready held low against a valid request
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_rf_wa", {27'd0, rf_wa}, 32'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;

        set_vec(0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'd0,        1'b1, 1'b0);
        set_vec(1,  1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b0, 1'b0);
`ifdef WB_ARB_RR_EN
        set_vec(2,  1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2,  32'hB2B2B2B2, 1'b0, 1'b1);
        set_vec(3,  1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2,  32'hB2B2B2B2, 1'b1, 1'b0);
        set_vec(4,  1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2,  32'hB2B2B2B2, 1'b0, 1'b1);
        set_vec(5,  1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2,  32'hB2B2B2B2, 1'b1, 1'b0);
`else
        set_vec(2,  1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2,  32'hB2B2B2B2, 1'b0, 1'b1);
        set_vec(3,  1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2,  32'hB2B2B2B2, 1'b0, 1'b1);
        set_vec(4,  1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2,  32'hB2B2B2B2, 1'b0, 1'b1);
        set_vec(5,  1'b1, 5'd1,  32'hA1A1A1A1, 1'b1, 5'd2,  32'hB2B2B2B2, 1'b0, 1'b1);
`endif
        set_vec(6,  1'b0, 5'd0,  32'd0,        1'b1, 5'd0,  32'h00001234, 1'b0, 1'b1);
        set_vec(7,  1'b0, 5'd0,  32'd0,        1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b1);
        set_vec(8,  1'b1, 5'd0,  32'h55555555, 1'b0, 5'd0,  32'd0,        1'b1, 1'b0);
        set_vec(9,  1'b1, 5'd9,  32'h99999999, 1'b1, 5'd10, 32'h10101010, 1'b0, 1'b1);
`ifdef WB_ARB_RR_EN
        set_vec(10, 1'b1, 5'd9,  32'h99999999, 1'b1, 5'd10, 32'h10101010, 1'b1, 1'b0);
`else
        set_vec(10, 1'b1, 5'd9,  32'h99999999, 1'b1, 5'd10, 32'h10101010, 1'b0, 1'b1);
`endif
        set_vec(11, 1'b0, 5'd0,  32'd0,        1'b0, 5'd0,  32'd0,        1'b0, 1'b0);

        model = '{1'b0, 5'd0, 32'd0};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adata;
            lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ldata;
            #1;
            chk($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].exp_ar});
            chk($sformatf("v%0d_lsu_ready", i), {31'd0, lsu_ready}, {31'd0, vecs[i].exp_lr});
            if (vecs[i].exp_lr) begin
                model.we = (vecs[i].lrd != 5'd0);
                model.wa = vecs[i].lrd;
                model.wd = vecs[i].ldata;
            end else if (vecs[i].exp_ar) begin
                model.we = (vecs[i].ard != 5'd0);
                model.wa = vecs[i].ard;
                model.wd = vecs[i].adata;
            end else begin
                model.we = 1'b0;
            end
            exp_q.push_back(model);
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            chk($sformatf("v%0d_rf_we", i), {31'd0, rf_we}, {31'd0, got.we});
            chk($sformatf("v%0d_rf_wa", i), {27'd0, rf_wa}, {27'd0, got.wa});
            chk($sformatf("v%0d_rf_wd", i), rf_wd, got.wd);
        end
        @(negedge clk);
        drive_idle();
        chk("tbl_idle", {31'd0, idle}, 32'd1);

        // Hazard on r7: set at issue, cleared by writeback with same-cycle forwarding
        iss_valid = 1'b1; iss_rd = 5'd7; chk_ra1 = 5'd7;
        @(negedge clk);
        iss_valid = 1'b0;
        chk("haz7_stall_set", {31'd0, stall}, 32'd1);
        chk("haz7_not_idle", {31'd0, idle}, 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77777777;
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        chk("haz7_rf_we", {31'd0, rf_we}, 32'd1);
        chk("haz7_rf_wa", {27'd0, rf_wa}, 32'd7);
        chk("haz7_fwd_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("haz7_cleared_stall", {31'd0, stall}, 32'd0);
        chk("haz7_idle", {31'd0, idle}, 32'd1);

        // Issue and writeback collide on r3: set must win
        @(negedge clk);
        chk_ra1 = 5'd0; chk_ra2 = 5'd3;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33333333;
        @(negedge clk);
        alu_valid = 1'b0;
        chk("col3_rf_we", {31'd0, rf_we}, 32'd1);
        iss_valid = 1'b1; iss_rd = 5'd3;
        @(negedge clk);
        iss_valid = 1'b0;
        chk("col3_stall", {31'd0, stall}, 32'd1);
        chk("col3_not_idle", {31'd0, idle}, 32'd0);
        @(negedge clk);
        chk("col3_stall_hold", {31'd0, stall}, 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd3;
        @(negedge clk);
        alu_valid = 1'b0;
        @(negedge clk);
        chk("col3_idle_after", {31'd0, idle}, 32'd1);

        // Issue to x0 never marks anything busy
        chk_ra1 = 5'd0; chk_ra2 = 5'd0;
        iss_valid = 1'b1; iss_rd = 5'd0;
        @(negedge clk);
        iss_valid = 1'b0;
        chk("x0_idle", {31'd0, idle}, 32'd1);
        chk("x0_stall", {31'd0, stall}, 32'd0);

        // Asynchronous reset mid-cycle with a write in flight and r12 busy
        iss_valid = 1'b1; iss_rd = 5'd12; chk_ra1 = 5'd12;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44444444;
        @(posedge clk);
        #2;
        chk("prerst_rf_we", {31'd0, rf_we}, 32'd1);
        chk("prerst_not_idle", {31'd0, idle}, 32'd0);
        reset = 1'b0;
        #1;
        chk("arst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("arst_idle", {31'd0, idle}, 32'd1);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_alu_ready", {31'd0, alu_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_rf_wa", {27'd0, rf_wa}, 32'd0);
        @(negedge clk);
        iss_valid = 1'b0; alu_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_rf_we", {31'd0, rf_we}, 32'd0);
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66666666;
        #1;
        chk("rel_alu_ready", {31'd0, alu_ready}, 32'd1);
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
        chk("rel_rf_we_after", {31'd0, rf_we}, 32'd1);
        chk("rel_rf_wd", rf_wd, 32'h66666666);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports alu_valid input 1, alu_rd input 5, alu_data input 32 for the ALU writeback request; alu_ready output 1 is its grant.
REQ-004 SHALL have ports lsu_valid input 1, lsu_rd input 5, lsu_data input 32 for the load-unit writeback request; lsu_ready output 1 is its grant.
REQ-005 SHALL have ports rf_we output 1, rf_wa output 5, rf_wd output 32, all registered, driving the register file write port (we3/wa3/wd3).
REQ-006 SHALL have ports iss_valid input 1, iss_rd input 5 marking a destination register as pending at issue.
REQ-007 SHALL have ports chk_ra1 input 5, chk_ra2 input 5, stall output 1 (combinational hazard indication).
REQ-008 SHALL have port idle output 1, high when no register is pending.

Function
REQ-009 SHALL grant at most one requester per cycle; a transfer occurs when valid and ready are both high; ready SHALL be combinational from valid and arbitration state.
REQ-010 SHALL never deassert ready to a lone valid requester (write port is never back-pressured).
REQ-011 SHALL present a transfer accepted in cycle N on rf_we/rf_wa/rf_wd during cycle N+1 (latency 1); with no transfer, rf_we SHALL be 0 in N+1 and rf_wa/rf_wd hold their previous values.
REQ-012 SHALL accept (ready=1) a request with rd=0 but keep rf_we=0 for it.
REQ-013 SHALL keep a 32-bit busy bitmap: bit set at edge when iss_valid and iss_rd!=0; bit cleared at edge when rf_we and rf_wa selects it.
REQ-014 SHALL give set priority over clear when issue and writeback target the same register in one cycle (bit stays 1).
REQ-015 SHALL never set bit 0; busy[0] reads 0 always.
REQ-016 SHALL drive stall=1 when, for either chk_ra1 or chk_ra2, the address is nonzero, its busy bit is 1, and it does not equal rf_wa while rf_we=1 (matches the register file same-cycle forwarding).
REQ-017 SHALL drive idle=1 exactly when all busy bits are 0.
REQ-018 SHALL, when both requesters are valid, select per REQ-024/REQ-025; the loser's ready SHALL be 0 and it must hold its request stable.

Reset
REQ-019 SHALL, while reset is low, force rf_we=0, rf_wa=0, rf_wd=0, busy=0, last-grant=ALU, asynchronously.
REQ-020 SHALL drive alu_ready=lsu_ready=0 and stall=0 while reset is low; idle=1.
REQ-021 SHALL drop any transfer accepted in the cycle reset asserts; no rf_we after release.
REQ-022 SHALL resume normal arbitration on the first rising edge after reset deasserts.

Configuration
REQ-023 SHALL use macro WB_ARB_RR_EN to select arbitration policy.
REQ-024 With WB_ARB_RR_EN defined: round-robin; on contention grant the requester not granted most recently; a 1-bit last-grant register updates on every transfer.
REQ-025 Without WB_ARB_RR_EN: fixed priority, LSU wins contention; last-grant register is absent.

Structure
REQ-026 SHALL place reg_addr_t (5 bit), xlen_t (32 bit), NUM_REGS=32 and enum wb_src_t {WB_ALU, WB_LSU} in shared package regfile_pkg.
REQ-027 SHALL implement the busy bitmap, stall and idle logic in sub-module regfile_scoreboard; arbitration and output register stay in regfile_wb_ctrl.

Verification
REQ-028 Reset low, then alu_valid=1 rd=5 data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rf_we=1 rf_wa=5 rf_wd=0xDEADBEEF.
REQ-029 alu and lsu valid together for 4 cycles (rd=1/2) -> RR: grants LSU,ALU,LSU,ALU; fixed: LSU each cycle, alu_ready=0.
REQ-030 iss_valid rd=7, chk_ra1=7 -> stall=1 next cycle; writeback rd=7 -> stall=0 in the cycle rf_we=1 rf_wa=7; busy[7]=0 after; idle=1.
REQ-031 iss_valid rd=3 in the same cycle rf_we=1 rf_wa=3 -> busy[3] remains 1, stall for chk_ra2=3 stays 1 afterward.
REQ-032 lsu_valid rd=0 data=0x1234 -> lsu_ready=1, rf_we stays 0; iss_valid rd=0 -> idle stays 1, stall for chk_ra1=0 is 0.
REQ-033 Assert reset with rf_we=1 and busy nonzero -> rf_we=0, busy=0, idle=1 immediately, no clock needed.
